axil_regfile: RTL and testbench

AXI-Lite peripheral (responder) exposing a bank of NUM_REGS read/write registers to an AXI-Lite main. It accepts write address and write data independently, commits byte-strobed writes, answers reads with one-cycle latency, and flags out-of-range accesses with SLVERR. The register contents and per-register write pulses are exported flat to the surrounding control logic.

---
 rtl/axil_regfile.sv | 170 +++++++++++++++++
 tb/tb_axil_regfile.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_regfile.sv
// AXI-Lite responder with a bank of NUM_REGS byte-strobed read/write registers.
// Register contents and per-register write-commit pulses are exported flat.
module axil_regfile #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_REGS      = 16
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [ADDRESS_WIDTH-1:0]       awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDRESS_WIDTH-1:0]       araddr,
    input  logic [2:0]                     arprot,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int TOP    = LSB + IDX_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write-side holding registers; the address is kept already decoded.
    logic                  aw_held_reg;
    logic                  aw_ok_reg;
    logic [IDX_W-1:0]      aw_idx_reg;
    logic                  w_held_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [STRB_W-1:0]     w_strb_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;

    logic                  rvalid_reg;
    logic [1:0]            rresp_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic                  aw_in_range;
    logic                  ar_in_range;
    logic [IDX_W-1:0]      aw_idx;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] rd_sel;
    logic                  unused_bits;

    assign awready = reset_n && !aw_held_reg && !bvalid_reg;
    assign wready  = reset_n && !w_held_reg && !bvalid_reg;
    assign arready = reset_n && !rvalid_reg;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign commit = aw_held_reg && w_held_reg && !bvalid_reg;

    assign aw_idx      = awaddr[LSB +: IDX_W];
    assign ar_idx      = araddr[LSB +: IDX_W];
    assign aw_in_range = (awaddr[ADDRESS_WIDTH-1:TOP] == '0);
    assign ar_in_range = (araddr[ADDRESS_WIDTH-1:TOP] == '0);
    assign rd_sel      = regs_q[ar_idx*DATA_WIDTH +: DATA_WIDTH];

    // Protection bits and sub-word address bits carry no meaning here.
    assign unused_bits = ^{awprot, arprot, awaddr[LSB-1:0], araddr[LSB-1:0]};

    assign bvalid = bvalid_reg;
    assign bresp  = bresp_reg;
    assign rvalid = rvalid_reg;
    assign rresp  = rresp_reg;
    assign rdata  = rdata_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            aw_held_reg <= 1'b0;
            aw_ok_reg   <= 1'b0;
            aw_idx_reg  <= '0;
            w_held_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= aw_idx;
                aw_ok_reg   <= aw_in_range;
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                w_data_reg <= wdata;
                w_strb_reg <= wstrb;
            end
            // commit needs both holds set, so it never coincides with a new handshake
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= aw_ok_reg ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_reg && bready) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] value_reg;
            logic                  pulse_reg;
            logic                  hit;

            assign hit = commit && aw_ok_reg && (aw_idx_reg == IDX_W'(gi));

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    value_reg <= '0;
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= hit;
                    if (hit) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (w_strb_reg[b]) begin
                                value_reg[b*8 +: 8] <= w_data_reg[b*8 +: 8];
                            end
                        end
                    end
                end
            end

            assign regs_q[gi*DATA_WIDTH +: DATA_WIDTH] = value_reg;
            assign wr_pulse[gi] = pulse_reg;
        end
    endgenerate

    // Read samples the pre-commit register value when it lands on a commit cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_reg <= 1'b0;
            rresp_reg  <= RESP_OKAY;
            rdata_reg  <= '0;
        end else begin
            if (ar_hs) begin
                rvalid_reg <= 1'b1;
                rresp_reg  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                rdata_reg  <= ar_in_range ? rd_sel : '0;
            end else if (rvalid_reg && rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_regfile.sv
// Self-checking bench for axil_regfile: directed scenarios plus randomized
// traffic compared against an array-based model of the register bank.
module tb_axil_regfile;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 16;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [AW-1:0]  awaddr;
    logic [2:0]     awprot;
    logic           awvalid;
    logic           awready;
    logic [DW-1:0]  wdata;
    logic [DW/8-1:0] wstrb;
    logic           wvalid;
    logic           wready;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;
    logic [AW-1:0]  araddr;
    logic [2:0]     arprot;
    logic           arvalid;
    logic           arready;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rvalid;
    logic           rready;
    logic [NR*DW-1:0] regs_q;
    logic [NR-1:0]  wr_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model [NR];

    axil_regfile #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clock(clock), .reset_n(reset_n),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_q(regs_q), .wr_pulse(wr_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit in_range(input logic [31:0] addr);
        return addr < NR * 4;
    endfunction

    function automatic int reg_index(input logic [31:0] addr);
        return (addr / 4) % NR;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) res[b*8 +: 8] = strb[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
        return res;
    endfunction

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < NR; i++) check(tag, regs_q[i*32 +: 32], model[i]);
    endtask

    // Write with AW offered at cycle aw_at, W at w_at, and bready held low bhold cycles.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_at, input int w_at,
                            input int bhold);
        int  aw_c = -1;
        int  w_c  = -1;
        bit  ok;
        logic [15:0] exp_pulse;
        logic [1:0]  exp_resp;
        ok        = in_range(addr);
        exp_pulse = ok ? (16'h1 << reg_index(addr)) : 16'h0;
        exp_resp  = ok ? 2'b00 : 2'b10;
        awaddr = addr; wdata = data; wstrb = strb; bready = 1'b0;
        for (int c = 0; c < 40 && (aw_c < 0 || w_c < 0); c++) begin
            awvalid = (c >= aw_at) && (aw_c < 0);
            wvalid  = (c >= w_at) && (w_c < 0);
            if (awvalid && awready) aw_c = c;
            if (wvalid && wready) w_c = c;
            if (c > 0) check("bvalid_early", {63'd0, bvalid}, 64'd0);
            tick();
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (aw_c < 0 || w_c < 0) begin
            check("write_handshake_timeout", 64'd0, 64'd1);
            return;
        end
        check("aw_accept_cycle", 64'(aw_c), 64'(aw_at));
        check("w_accept_cycle", 64'(w_c), 64'(w_at));
        check("commit_cycle_bvalid", {63'd0, bvalid}, 64'd0);
        tick();
        check("bvalid_latency", {63'd0, bvalid}, 64'd1);
        check("bresp", {62'd0, bresp}, {62'd0, exp_resp});
        check("wr_pulse_first", {48'd0, wr_pulse}, {48'd0, exp_pulse});
        if (ok) model[reg_index(addr)] = merge(model[reg_index(addr)], data, strb);
        check_all_regs("regs_after_write");
        for (int i = 0; i < bhold; i++) begin
            check("awready_while_b", {63'd0, awready}, 64'd0);
            check("wready_while_b", {63'd0, wready}, 64'd0);
            tick();
            check("bvalid_held", {63'd0, bvalid}, 64'd1);
            check("bresp_held", {62'd0, bresp}, {62'd0, exp_resp});
            check("wr_pulse_once", {48'd0, wr_pulse}, 64'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_clear", {63'd0, bvalid}, 64'd0);
        check("wr_pulse_after", {48'd0, wr_pulse}, 64'd0);
        check("awready_after_b", {63'd0, awready}, 64'd1);
        $display("WR addr=0x%08h data=0x%08h strb=%b resp=%b", addr, data, strb, exp_resp);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rhold);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        exp_data = in_range(addr) ? model[reg_index(addr)] : 32'h0;
        exp_resp = in_range(addr) ? 2'b00 : 2'b10;
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        check("arready_idle", {63'd0, arready}, 64'd1);
        tick();
        arvalid = 1'b0;
        check("rvalid_latency", {63'd0, rvalid}, 64'd1);
        check("rdata", {32'd0, rdata}, {32'd0, exp_data});
        check("rresp", {62'd0, rresp}, {62'd0, exp_resp});
        for (int i = 0; i < rhold; i++) begin
            check("arready_while_r", {63'd0, arready}, 64'd0);
            tick();
            check("rvalid_held", {63'd0, rvalid}, 64'd1);
            check("rdata_held", {32'd0, rdata}, {32'd0, exp_data});
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rvalid_clear", {63'd0, rvalid}, 64'd0);
        $display("RD addr=0x%08h data=0x%08h resp=%b", addr, exp_data, exp_resp);
    endtask

    initial begin
        reset_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        #1;
        check("rst_awready", {63'd0, awready}, 64'd0);
        check("rst_wready", {63'd0, wready}, 64'd0);
        check("rst_arready", {63'd0, arready}, 64'd0);
        check("rst_bvalid", {63'd0, bvalid}, 64'd0);
        check("rst_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_rdata", {32'd0, rdata}, 64'd0);
        check("rst_wr_pulse", {48'd0, wr_pulse}, 64'd0);
        check_all_regs("rst_regs");
        tick(); tick();
        reset_n = 1'b1;
        #1;
        check("first_awready", {63'd0, awready}, 64'd1);
        check("first_wready", {63'd0, wready}, 64'd1);
        check("first_arready", {63'd0, arready}, 64'd1);
        tick();

        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(32'h04, 0);

        do_write(32'h0C, 32'h11223344, 4'hF, 0, 0, 0);
        do_write(32'h0C, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        check("strobe_merge", {32'd0, regs_q[3*32 +: 32]}, 64'h11BB33DD);

        do_write(32'h20, 32'h5A5A0001, 4'hF, 3, 0, 4);

        do_write(32'h100, 32'hFFFFFFFF, 4'hF, 0, 0, 1);
        do_read(32'h100, 1);

        do_write(32'h28, 32'hCAFEF00D, 4'h0, 0, 2, 0);

        // Read handshake lands in the commit cycle of a write to the same register.
        do_write(32'h14, 32'h1, 4'hF, 0, 0, 0);
        awaddr = 32'h14; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h14; arvalid = 1'b1;
        check("collide_arready", {63'd0, arready}, 64'd1);
        tick();
        arvalid = 1'b0;
        check("collide_rvalid", {63'd0, rvalid}, 64'd1);
        check("collide_rdata_old", {32'd0, rdata}, 64'h1);
        check("collide_bvalid", {63'd0, bvalid}, 64'd1);
        model[5] = 32'h2;
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        $display("WR+RD collision reg5 old=0x1 new=0x2");
        do_read(32'h14, 0);

        // Reset while an AW is held and W has not arrived.
        awaddr = 32'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("aw_held_awready", {63'd0, awready}, 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_awready", {63'd0, awready}, 64'd0);
        check("midrst_arready", {63'd0, arready}, 64'd0);
        check("midrst_bvalid", {63'd0, bvalid}, 64'd0);
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        check_all_regs("midrst_regs");
        tick(); tick();
        reset_n = 1'b1;
        #1;
        check("postrst_awready", {63'd0, awready}, 64'd1);
        check("postrst_wready", {63'd0, wready}, 64'd1);
        check("postrst_arready", {63'd0, arready}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("postrst_bvalid", {63'd0, bvalid}, 64'd0);
            check("postrst_wr_pulse", {48'd0, wr_pulse}, 64'd0);
        end
        check_all_regs("postrst_regs");
        $display("RST mid-transaction discarded");

        for (int t = 0; t < 60; t++) begin
            logic [31:0] addr;
            if ($urandom_range(0, 7) == 0) addr = $urandom_range(64, 32'h3FF);
            else addr = $urandom_range(0, NR * 4 - 1);
            if ($urandom_range(0, 1) == 0)
                do_write(addr, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(addr, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
